// File: rtl/class_pio_mst_if.sv
// Command / PIO / response bundle for the classifier value-memory PIO initiator.
// master = the initiator (class_pio_mst); slave = the command source plus the PIO target side.
interface class_pio_mst_if #(
    parameter int ENTRY_IDX_W = 16,
    parameter int NWORDS      = 9
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_wr;
    logic [ENTRY_IDX_W-1:0]   cmd_idx;
    logic [NWORDS*32-1:0]     cmd_wdata;

    logic                     pio_req;
    logic                     pio_rw;
    logic [31:0]              pio_addr;
    logic [31:0]              pio_wdata;
    logic                     pio_ack;
    logic [31:0]              pio_rdata;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [NWORDS*32-1:0]     rsp_rdata;
    logic                     rsp_err;

    modport master (
        input  cmd_valid, cmd_wr, cmd_idx, cmd_wdata, pio_ack, pio_rdata, rsp_ready,
        output cmd_ready, pio_req, pio_rw, pio_addr, pio_wdata, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_idx, cmd_wdata, pio_ack, pio_rdata, rsp_ready,
        input  cmd_ready, pio_req, pio_rw, pio_addr, pio_wdata, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/class_pio_mst.sv
// Splits one 288-bit value-memory entry read/write into NWORDS sequential 32-bit PIO transactions.
// Optional ack watchdog enabled by defining CLASS_PIO_TIMEOUT_EN.
module class_pio_mst #(
    parameter int         NWORDS       = 9,
    parameter int         ENTRY_IDX_W  = 16,
    parameter logic [9:0] MEM_BLK_ADDR = 10'h004,
    parameter int         TIMEOUT_CYC  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    class_pio_mst_if.master  bus
);
    localparam int ENTRY_W = NWORDS * 32;
    localparam int OFF_W   = 22;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP, S_RSP} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_cnt;
    logic                 r_wr;
    logic [ENTRY_IDX_W-1:0] r_idx;
    logic [ENTRY_W-1:0]   r_wdata;
    logic [ENTRY_W-1:0]   r_rdata;
    logic                 w_accept;
    logic                 w_ack;
    logic                 w_last;
    logic                 w_timeout;
    logic [OFF_W-1:0]     w_off;
    logic [8:0]           w_sel;

    assign w_accept = bus.cmd_valid & bus.cmd_ready;
    // Acks outside BUS (IDLE, GAP, RSP, drop cycle) never reach the datapath.
    assign w_ack    = (r_state == S_BUS) & bus.pio_ack;
    assign w_last   = (r_cnt == 4'(NWORDS - 1));
    assign w_sel    = {r_cnt, 5'b00000};
    assign w_off    = OFF_W'({r_idx, r_cnt, 2'b00});

`ifdef CLASS_PIO_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1) + 1;

    logic [WDOG_W-1:0] r_wdog;
    logic              r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (r_state != S_BUS || bus.pio_ack) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_BUS) && !bus.pio_ack &&
                       (r_wdog == WDOG_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign bus.rsp_err = r_err;
`else
    assign w_timeout   = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_BUS;
            S_BUS: begin
                if (w_ack) begin
                    w_next = w_last ? S_RSP : S_GAP;
                end else if (w_timeout) begin
                    w_next = S_RSP;
                end
            end
            S_GAP: w_next = S_BUS;
            S_RSP: if (bus.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.pio_req   = 1'b0;
        bus.pio_rw    = 1'b0;
        bus.pio_addr  = '0;
        bus.pio_wdata = '0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: bus.cmd_ready = rst_n;
            S_BUS: begin
                bus.pio_req   = 1'b1;
                bus.pio_rw    = r_wr;
                bus.pio_addr  = {MEM_BLK_ADDR, w_off};
                bus.pio_wdata = r_wr ? r_wdata[w_sel +: 32] : 32'h0;
            end
            S_RSP: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_idx   <= '0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_wr    <= bus.cmd_wr;
            r_idx   <= bus.cmd_idx;
            r_rdata <= '0;
        end else if (w_ack) begin
            if (!r_wr) r_rdata[w_sel +: 32] <= bus.pio_rdata;
            if (!w_last) r_cnt <= r_cnt + 4'd1;
        end
    end

    // Write payload is pure data: captured on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) r_wdata <= bus.cmd_wdata;
    end

    assign bus.rsp_rdata = r_rdata;
endmodule

// File: tb/tb_class_pio_mst.sv
// Bench for class_pio_mst: PIO target responder, entry-level reference model, vector table and random runs.
// Define CLASS_PIO_TIMEOUT_EN to build and exercise the watchdog variant (TIMEOUT_CYC=16).
module tb_class_pio_mst;
    localparam int NW = 9;
    localparam int EW = NW * 32;
`ifdef CLASS_PIO_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    class_pio_mst_if #(.ENTRY_IDX_W(16), .NWORDS(NW)) ifc ();

    class_pio_mst #(
        .NWORDS(NW), .ENTRY_IDX_W(16), .MEM_BLK_ADDR(10'h004), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc.master)
    );

    // Target responder state
    int          wait_cfg = 0;
    bit          spur_en = 0;
    bit          never_en = 0;
    int          never_word = 0;
    int          rd_mode = 0;
    logic [31:0] rd_salt = 32'h3C5A_0F96;
    int          stab_err = 0;
    logic [31:0] log_addr[$];
    bit          log_rw[$];
    logic [31:0] log_wd[$];

    int               last_t0, last_hs;
    bit               nx_wr;
    logic [15:0]      nx_idx;
    logic [EW-1:0]    nx_wd;

    task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        logic [3:0] k;
        k = a[5:2];
        if (rd_mode == 0) return 32'h1111_1111 * ({28'd0, k} + 32'd1);
        return (a * 32'h9E37_79B9) ^ rd_salt;
    endfunction

    // Reference address of word k of entry idx: block base + 64 bytes per entry slot + 4 per word.
    function automatic logic [31:0] m_addr(input logic [15:0] idx, input int k);
        return 32'h0100_0000 + 32'(idx) * 32'd64 + 32'(k) * 32'd4;
    endfunction

    initial begin
        int          wcnt;
        logic [31:0] c_addr, c_wd;
        logic        c_rw;
        wcnt = 0;
        c_addr = 0; c_wd = 0; c_rw = 0;
        ifc.pio_ack = 1'b0;
        ifc.pio_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ifc.pio_ack = 1'b0;
                wcnt = 0;
            end else if (ifc.pio_req) begin
                if (wcnt == 0) begin
                    c_addr = ifc.pio_addr; c_wd = ifc.pio_wdata; c_rw = ifc.pio_rw;
                end else if (ifc.pio_addr !== c_addr || ifc.pio_wdata !== c_wd || ifc.pio_rw !== c_rw) begin
                    stab_err++;
                end
                if (never_en && int'(ifc.pio_addr[5:2]) == never_word) begin
                    ifc.pio_ack = 1'b0;
                    wcnt++;
                end else if (wcnt >= wait_cfg) begin
                    ifc.pio_ack = 1'b1;
                    ifc.pio_rdata = rd_of(ifc.pio_addr);
                    log_addr.push_back(ifc.pio_addr);
                    log_rw.push_back(ifc.pio_rw);
                    log_wd.push_back(ifc.pio_wdata);
                    wcnt = 0;
                end else begin
                    ifc.pio_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                ifc.pio_ack = spur_en ? 1'($urandom % 2) : 1'b0;
                ifc.pio_rdata = $urandom;
                wcnt = 0;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_rw.delete();
        log_wd.delete();
        stab_err = 0;
    endtask

    task automatic run_cmd(input bit wr, input logic [15:0] idx, input logic [EW-1:0] wd,
                           input int w, input int rdy_dly, input int exp_lat, input int exp_words,
                           input bit exp_err, input bit keep_valid, input string tag);
        int            t0, bad_rdy, bad_hold, lim, n;
        logic [EW-1:0] exp_rd, held;
        wait_cfg = w;
        clear_log();
        ifc.cmd_wr = wr; ifc.cmd_idx = idx; ifc.cmd_wdata = wd; ifc.cmd_valid = 1'b1;
        lim = 0;
        while (!ifc.cmd_ready && lim < 50) begin step(); lim++; end
        chk({tag, "_accept"}, ifc.cmd_ready, 1);
        t0 = cyc; last_t0 = t0;
        step();
        if (keep_valid) begin
            ifc.cmd_wr = nx_wr; ifc.cmd_idx = nx_idx; ifc.cmd_wdata = nx_wd;
        end else begin
            ifc.cmd_valid = 1'b0;
        end
        bad_rdy = 0; lim = 0;
        while (!ifc.rsp_valid && lim < 2000) begin
            if (ifc.cmd_ready) bad_rdy++;
            step(); lim++;
        end
        chk({tag, "_rsp_valid"}, ifc.rsp_valid, 1);
        if (exp_lat > 0) chk({tag, "_latency"}, cyc - t0, exp_lat);
        exp_rd = '0;
        for (int k = 0; k < exp_words; k++)
            if (!wr) exp_rd[k*32 +: 32] = rd_of(m_addr(idx, k));
        chk({tag, "_rdata"}, ifc.rsp_rdata, exp_rd);
        chk({tag, "_err"}, ifc.rsp_err, exp_err);
        held = ifc.rsp_rdata; bad_hold = 0;
        repeat (rdy_dly) begin
            step();
            if (!ifc.rsp_valid || ifc.rsp_rdata !== held || ifc.cmd_ready) bad_hold++;
        end
        ifc.rsp_ready = 1'b1;
        last_hs = cyc;
        step();
        ifc.rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, ifc.rsp_valid, 0);
        chk({tag, "_ready_back"}, ifc.cmd_ready, 1);
        chk({tag, "_busy_ready"}, bad_rdy, 0);
        chk({tag, "_rsp_hold"}, bad_hold, 0);
        chk({tag, "_pio_stable"}, stab_err, 0);
        chk({tag, "_nwords"}, log_addr.size(), exp_words);
        n = (log_addr.size() < exp_words) ? log_addr.size() : exp_words;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_addr%0d", tag, k), log_addr[k], m_addr(idx, k));
            chk($sformatf("%s_rw%0d", tag, k), log_rw[k], wr);
            chk($sformatf("%s_wd%0d", tag, k), log_wd[k], wr ? wd[k*32 +: 32] : 32'h0);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] idx;
        logic [31:0] wbase;
        int          w;
        int          rdy;
        bit          spur;
        int          rdm;
        int          exp_lat;
        logic [31:0] exp_a0;
    } vec_t;

    vec_t tv[4];

    initial begin
        logic [EW-1:0] wd;
        bit            wr;
        int            w, lim, hs;
        logic [15:0]   idx;

        tv[0] = '{1'b1, 16'h0012, 32'hA000_0000, 0, 0, 1'b0, 0, 18, 32'h0100_0480};
        tv[1] = '{1'b0, 16'h0000, 32'h0,         3, 0, 1'b0, 0, 45, 32'h0100_0000};
        tv[2] = '{1'b0, 16'hFFFF, 32'h0,         1, 5, 1'b1, 1, 27, 32'h013F_FFC0};
        tv[3] = '{1'b1, 16'h0001, 32'h5555_0000, 2, 2, 1'b1, 1, 36, 32'h0100_0040};

        ifc.cmd_valid = 1'b0; ifc.cmd_wr = 1'b0; ifc.cmd_idx = '0; ifc.cmd_wdata = '0;
        ifc.rsp_ready = 1'b0;

        #12;
        chk("rst_cmd_ready", ifc.cmd_ready, 0);
        chk("rst_pio_req", ifc.pio_req, 0);
        chk("rst_pio_addr", ifc.pio_addr, 0);
        chk("rst_pio_wdata", ifc.pio_wdata, 0);
        chk("rst_rsp_valid", ifc.rsp_valid, 0);
        chk("rst_rsp_rdata", ifc.rsp_rdata, 0);
        chk("rst_rsp_err", ifc.rsp_err, 0);
        #23 rst_n = 1'b1;
        spur_en = 1'b1;
        repeat (4) step();
        spur_en = 1'b0;
        chk("idle_ready", ifc.cmd_ready, 1);
        chk("idle_spur_rdata", ifc.rsp_rdata, 0);

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < NW; k++) wd[k*32 +: 32] = tv[i].wbase + 32'(k);
            rd_mode = tv[i].rdm;
            spur_en = tv[i].spur;
            run_cmd(tv[i].wr, tv[i].idx, wd, tv[i].w, tv[i].rdy, tv[i].exp_lat, NW, 1'b0, 1'b0,
                    $sformatf("vec%0d", i));
            spur_en = 1'b0;
            chk($sformatf("vec%0d_first_addr", i), (log_addr.size() > 0) ? log_addr[0] : 32'hx, tv[i].exp_a0);
            if (i == 1) begin
                chk("vec1_word0", ifc.rsp_rdata[31:0], 32'h1111_1111);
                chk("vec1_word8", ifc.rsp_rdata[287:256], 32'h9999_9999);
            end
        end

        // Second command held valid through the first: accepted the cycle after the response handshake.
        rd_mode = 1;
        for (int k = 0; k < NW; k++) wd[k*32 +: 32] = $urandom;
        nx_wr = 1'b0; nx_idx = 16'h0033; nx_wd = '0;
        run_cmd(1'b1, 16'h0022, wd, 0, 5, 18, NW, 1'b0, 1'b1, "b2b1");
        hs = last_hs;
        run_cmd(1'b0, 16'h0033, '0, 0, 0, 18, NW, 1'b0, 1'b0, "b2b2");
        chk("b2b_second_start", last_t0, hs + 1);

        for (int r = 0; r < 10; r++) begin
            wr  = 1'($urandom % 2);
            idx = 16'($urandom);
            w   = int'($urandom % 4);
            for (int k = 0; k < NW; k++) wd[k*32 +: 32] = $urandom;
            rd_salt = $urandom;
            spur_en = 1'($urandom % 2);
            run_cmd(wr, idx, wd, w, int'($urandom % 4), 9 * w + 18, NW, 1'b0, 1'b0,
                    $sformatf("rnd%0d", r));
            spur_en = 1'b0;
        end

        // Asynchronous reset during word 4 of a write.
        wait_cfg = 1;
        clear_log();
        for (int k = 0; k < NW; k++) wd[k*32 +: 32] = $urandom;
        ifc.cmd_wr = 1'b1; ifc.cmd_idx = 16'h0005; ifc.cmd_wdata = wd; ifc.cmd_valid = 1'b1;
        lim = 0;
        while (!ifc.cmd_ready && lim < 50) begin step(); lim++; end
        step();
        ifc.cmd_valid = 1'b0;
        lim = 0;
        while (!(ifc.pio_req && ifc.pio_addr[5:2] == 4'd4) && lim < 100) begin step(); lim++; end
        chk("rstmid_word4_seen", ifc.pio_req, 1);
        chk("rstmid_words_before", log_addr.size(), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_pio_req", ifc.pio_req, 0);
        chk("rstmid_pio_rw", ifc.pio_rw, 0);
        chk("rstmid_pio_addr", ifc.pio_addr, 0);
        chk("rstmid_pio_wdata", ifc.pio_wdata, 0);
        chk("rstmid_cmd_ready", ifc.cmd_ready, 0);
        chk("rstmid_rsp_valid", ifc.rsp_valid, 0);
        repeat (2) step();
        #3 rst_n = 1'b1;
        spur_en = 1'b1;
        repeat (3) step();
        spur_en = 1'b0;
        chk("rstmid_idle_ready", ifc.cmd_ready, 1);
        chk("rstmid_idle_req", ifc.pio_req, 0);
        rd_mode = 1;
        run_cmd(1'b0, 16'h0001, '0, 0, 0, 18, NW, 1'b0, 1'b0, "rst_rd");

`ifdef CLASS_PIO_TIMEOUT_EN
        // Word 2 never acked: req high 16 cycles at T+5..T+20, response at T+21 with error.
        never_en = 1'b1; never_word = 2;
        run_cmd(1'b0, 16'h0003, '0, 0, 0, 21, 2, 1'b1, 1'b0, "tmo");
        never_en = 1'b0;
        run_cmd(1'b0, 16'h0004, '0, 0, 0, 18, NW, 1'b0, 1'b0, "tmo_after");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end
endmodule
